// File: rtl/strobe_stretcher_if.sv
// Request/status bundle for strobe_stretcher: strobe/length/abort in, stretched level and drop status out.
// strobe is a per-cycle request with no back-pressure: every high cycle is one request, and length/abort are sampled with it on the same edge.
interface strobe_stretcher_if #(
   parameter int WIDTH  = 8,
   parameter int DROP_W = 8
);
   logic              strobe;
   logic [WIDTH-1:0]  length;
   logic              abort;
   logic              signal;
   logic              busy;
   logic              dropped;
   logic [DROP_W-1:0] drop_count;
   logic [1:0]        dbg_state;

   modport master (
      output strobe, length, abort,
      input  signal, busy, dropped, drop_count, dbg_state
   );

   modport slave (
      input  strobe, length, abort,
      output signal, busy, dropped, drop_count, dbg_state
   );
endinterface

// File: rtl/strobe_stretcher.sv
// Stretches accepted one-cycle strobes into a 'length'-cycle level, with optional retrigger,
// a forced low gap after each pulse, abort, and a saturating count of ignored strobes.
module strobe_stretcher #(
   parameter int WIDTH     = 8,
   parameter int RETRIGGER = 0,
   parameter int GAP       = 0,
   parameter int DROP_W    = 8
) (
   input  logic           clk,
   input  logic           reset,
   strobe_stretcher_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
   localparam logic [DROP_W-1:0] ONE_D    = DROP_W'(1);
   localparam bit                HAS_GAP  = (GAP > 0);
   localparam logic [WIDTH-1:0]  GAP_LOAD = (GAP > 0) ? WIDTH'(GAP - 1) : '0;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  gcnt_q, gcnt_d;
   logic              signal_q, signal_d;
   logic              busy_q, busy_d;
   logic              dropped_q, dropped_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gcnt_d     = gcnt_q;
      dropped_d  = 1'b0;
      // abort wins over any strobe in the same cycle, and that strobe is not counted
      if (bus.abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         gcnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.strobe) begin
                  if (bus.length != '0) begin
                     state_d = S_ACTIVE;
                     cnt_d   = bus.length - ONE_W;
                  end else begin
                     dropped_d = 1'b1;
                  end
               end
            end
            S_ACTIVE: begin
               if ((RETRIGGER != 0) && bus.strobe && (bus.length != '0)) begin
                  cnt_d = bus.length - ONE_W;
               end else begin
                  dropped_d = bus.strobe;
                  if (cnt_q == '0) begin
                     if (HAS_GAP) begin
                        state_d = S_GAP;
                        gcnt_d  = GAP_LOAD;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q - ONE_W;
                  end
               end
            end
            S_GAP: begin
               dropped_d = bus.strobe;
               if (gcnt_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  gcnt_d = gcnt_q - ONE_W;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      signal_d   = (state_d == S_ACTIVE);
      busy_d     = (state_d != S_IDLE);
      drop_cnt_d = (dropped_d && (drop_cnt_q != '1)) ? (drop_cnt_q + ONE_D) : drop_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         gcnt_q     <= '0;
         signal_q   <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gcnt_q     <= gcnt_d;
         signal_q   <= signal_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.signal     = signal_q;
   assign bus.busy       = busy_q;
   assign bus.dropped    = dropped_q;
   assign bus.drop_count = drop_cnt_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_strobe_stretcher.sv
// Bench for strobe_stretcher: three parameterisations share one stimulus stream; a
// timeline model (last high cycle / last busy cycle per instance) predicts every output.
module tb_strobe_stretcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       strobe_r;
   logic [7:0] length_r;
   logic       abort_r;

   always #5 clk = ~clk;

   strobe_stretcher_if #(.WIDTH(8), .DROP_W(8)) if_a ();
   strobe_stretcher_if #(.WIDTH(8), .DROP_W(8)) if_b ();
   strobe_stretcher_if #(.WIDTH(8), .DROP_W(2)) if_c ();

   assign if_a.strobe = strobe_r;
   assign if_a.length = length_r;
   assign if_a.abort  = abort_r;
   assign if_b.strobe = strobe_r;
   assign if_b.length = length_r;
   assign if_b.abort  = abort_r;
   assign if_c.strobe = strobe_r;
   assign if_c.length = length_r;
   assign if_c.abort  = abort_r;

   strobe_stretcher #(.WIDTH(8), .RETRIGGER(0), .GAP(0), .DROP_W(8)) u_a (
      .clk(clk), .reset(reset), .bus(if_a.slave));
   strobe_stretcher #(.WIDTH(8), .RETRIGGER(0), .GAP(2), .DROP_W(8)) u_b (
      .clk(clk), .reset(reset), .bus(if_b.slave));
   strobe_stretcher #(.WIDTH(8), .RETRIGGER(1), .GAP(3), .DROP_W(2)) u_c (
      .clk(clk), .reset(reset), .bus(if_c.slave));

   logic       sig_o  [3];
   logic       busy_o [3];
   logic       drp_o  [3];
   logic [7:0] dc_o   [3];

   assign sig_o[0]  = if_a.signal;
   assign sig_o[1]  = if_b.signal;
   assign sig_o[2]  = if_c.signal;
   assign busy_o[0] = if_a.busy;
   assign busy_o[1] = if_b.busy;
   assign busy_o[2] = if_c.busy;
   assign drp_o[0]  = if_a.dropped;
   assign drp_o[1]  = if_b.dropped;
   assign drp_o[2]  = if_c.dropped;
   assign dc_o[0]   = if_a.drop_count;
   assign dc_o[1]   = if_b.drop_count;
   assign dc_o[2]   = {6'd0, if_c.drop_count};

   // per-instance parameters and timeline model
   int r_p   [3] = '{0, 0, 1};
   int g_p   [3] = '{0, 2, 3};
   int max_p [3] = '{255, 255, 3};
   int hi    [3];
   int lo    [3];
   int mcnt  [3];
   bit mdrop [3];
   int cyc;
   int checks;
   int failures;

   task automatic model_clear;
      for (int i = 0; i < 3; i++) begin
         hi[i]    = -1;
         lo[i]    = -1;
         mcnt[i]  = 0;
         mdrop[i] = 1'b0;
      end
   endtask

   // one clock cycle 'cyc' with the given inputs; returns with cycle cyc+1 outputs settled
   task automatic step(input bit s, input int len, input bit ab);
      bit d;
      strobe_r = s;
      length_r = 8'(len);
      abort_r  = ab;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         d = 1'b0;
         if (ab) begin
            hi[i] = cyc;
            lo[i] = cyc;
         end else if (s) begin
            if (cyc <= hi[i]) begin
               if (r_p[i] == 1 && len != 0) begin
                  hi[i] = cyc + len;
                  lo[i] = hi[i] + g_p[i];
               end else begin
                  d = 1'b1;
               end
            end else if (cyc <= lo[i]) begin
               d = 1'b1;
            end else if (len != 0) begin
               hi[i] = cyc + len;
               lo[i] = hi[i] + g_p[i];
            end else begin
               d = 1'b1;
            end
         end
         mdrop[i] = d;
         if (d && mcnt[i] < max_p[i]) mcnt[i]++;
      end
      cyc++;
      #2;
   endtask

   task automatic do_reset;
      strobe_r = 1'b0;
      abort_r  = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      strobe_r = 1'b0;
      length_r = 8'd0;
      abort_r  = 1'b0;
      model_clear();
      cyc = 0;
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sig_o[i] !== 1'b0 || busy_o[i] !== 1'b0 || drp_o[i] !== 1'b0 || dc_o[i] !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d got sig=%b busy=%b drp=%b cnt=%0d exp all 0",
                     i, sig_o[i], busy_o[i], drp_o[i], dc_o[i]);
         end
      end
      @(posedge clk);
      #3 reset = 1'b0;
      step(1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sig_o[i] !== 1'b0 || busy_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset_release inst=%0d got sig=%b busy=%b exp 0 0", i, sig_o[i], busy_o[i]);
         end
      end
   endtask

   // length=3, one strobe: signal and busy high for relative cycles 1..3
   task automatic test_single;
      bit e;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         step(k == 0, 3, 1'b0);
         e = (k + 1 >= 1) && (k + 1 <= 3);
         checks++;
         if (if_a.signal !== e || if_a.busy !== e || if_a.dropped !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse rel=%0d got sig=%b busy=%b drp=%b exp sig=%b busy=%b drp=0",
                     k + 1, if_a.signal, if_a.busy, if_a.dropped, e, e);
         end
      end
   endtask

   // GAP=2 no retrigger, length=4, strobes at 0,2,5,7
   task automatic test_gap_drop;
      bit es, ed;
      int v;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 14; k++) begin
         step(k == 0 || k == 2 || k == 5 || k == 7, 4, 1'b0);
         v  = k + 1;
         es = (v >= 1 && v <= 4) || (v >= 8 && v <= 11);
         ed = (v == 3) || (v == 6);
         checks++;
         if (if_b.signal !== es || if_b.dropped !== ed) begin
            failures++;
            $display("FAIL gap_drop rel=%0d got sig=%b drp=%b exp sig=%b drp=%b",
                     v, if_b.signal, if_b.dropped, es, ed);
         end
      end
      checks++;
      if (if_b.drop_count !== 8'd2) begin
         failures++;
         $display("FAIL gap_drop_count got=%0d exp=2", if_b.drop_count);
      end
   endtask

   // retrigger: len 5 at 0, len 2 at 3 -> high 1..5 continuously, no drops
   task automatic test_retrigger;
      bit es;
      int v;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(k == 0 || k == 3, (k == 0) ? 5 : ((k == 3) ? 2 : $urandom_range(0, 9)), 1'b0);
         v  = k + 1;
         es = (v >= 1 && v <= 5);
         checks++;
         if (if_c.signal !== es || if_c.dropped !== 1'b0) begin
            failures++;
            $display("FAIL retrigger rel=%0d got sig=%b drp=%b exp sig=%b drp=0",
                     v, if_c.signal, if_c.dropped, es);
         end
      end
   endtask

   // five zero-length strobes: dropped each cycle, 2-bit count saturates at 3
   task automatic test_saturate;
      bit ed;
      int ec;
      int v;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         step(k < 5, 0, 1'b0);
         v  = k + 1;
         ed = (v <= 5);
         ec = (v < 3) ? v : 3;
         checks++;
         if (if_c.signal !== 1'b0 || if_c.dropped !== ed || if_c.drop_count !== 2'(ec)) begin
            failures++;
            $display("FAIL saturate rel=%0d got sig=%b drp=%b cnt=%0d exp sig=0 drp=%b cnt=%0d",
                     v, if_c.signal, if_c.dropped, if_c.drop_count, ed, ec);
         end
      end
   endtask

   // len 10 at 0, abort+strobe at 3, strobe at 5 -> high 1..3 and 6..15, count untouched
   task automatic test_abort;
      bit es;
      int v;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         step(k == 0 || k == 3 || k == 5, 10, k == 3);
         v  = k + 1;
         es = (v >= 1 && v <= 3) || (v >= 6 && v <= 15);
         checks++;
         if (if_a.signal !== es || if_a.busy !== es || if_a.drop_count !== 8'd0) begin
            failures++;
            $display("FAIL abort rel=%0d got sig=%b busy=%b cnt=%0d exp sig=%b busy=%b cnt=0",
                     v, if_a.signal, if_a.busy, if_a.drop_count, es, es);
         end
      end
   endtask

   // reset asserted mid-pulse clears outputs at once; a later strobe works normally
   task automatic test_async_reset;
      bit es;
      do_reset();
      repeat (2) step(1'b0, 0, 1'b0);
      step(1'b1, 8, 1'b0);
      step(1'b1, 8, 1'b0);
      checks++;
      if (if_a.signal !== 1'b1 || if_a.drop_count !== 8'd1) begin
         failures++;
         $display("FAIL pre_reset got sig=%b cnt=%0d exp sig=1 cnt=1", if_a.signal, if_a.drop_count);
      end
      strobe_r = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (if_a.signal !== 1'b0 || if_a.busy !== 1'b0 || if_a.drop_count !== 8'd0) begin
         failures++;
         $display("FAIL async_reset got sig=%b busy=%b cnt=%0d exp 0 0 0",
                  if_a.signal, if_a.busy, if_a.drop_count);
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      model_clear();
      repeat (3) step(1'b0, 0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(k == 0, 8, 1'b0);
         es = (k + 1 >= 1) && (k + 1 <= 8);
         checks++;
         if (if_a.signal !== es) begin
            failures++;
            $display("FAIL after_reset rel=%0d got=%b exp=%b", k + 1, if_a.signal, es);
         end
      end
   endtask

   task automatic test_random;
      bit s, ab;
      int len;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         s   = ($urandom_range(0, 99) < 40);
         ab  = ($urandom_range(0, 99) < 5);
         len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
         step(s, len, ab);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (sig_o[i] !== (cyc <= hi[i]) || busy_o[i] !== (cyc <= lo[i]) ||
                drp_o[i] !== mdrop[i] || dc_o[i] !== 8'(mcnt[i])) begin
               failures++;
               $display("FAIL random inst=%0d n=%0d got sig=%b busy=%b drp=%b cnt=%0d exp sig=%b busy=%b drp=%b cnt=%0d",
                        i, n, sig_o[i], busy_o[i], drp_o[i], dc_o[i],
                        (cyc <= hi[i]), (cyc <= lo[i]), mdrop[i], mcnt[i]);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_gap_drop();
      test_retrigger();
      test_saturate();
      test_abort();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
